// File: rtl/cu_pkg.sv
// Shared types and constants for the pipelined control unit: header fields,
// opcodes, ALU codes and the registered control bundle.
package cu_pkg;

  localparam int unsigned COND_W = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ALUC_W = 4;
  localparam int unsigned HDR_W  = COND_W + 3 + OP_W;

  typedef enum logic [1:0] {
    CL_DATA   = 2'b00,
    CL_MEM    = 2'b01,
    CL_BRANCH = 2'b10,
    CL_RSVD   = 2'b11
  } cls_e;

  localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(3);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(7);
  localparam logic [OP_W-1:0] OP_AVR = OP_W'(10);
  localparam logic [OP_W-1:0] OP_CUM = OP_W'(11);

  localparam logic [ALUC_W-1:0] ALUC_ADD  = ALUC_W'(1);
  localparam logic [ALUC_W-1:0] ALUC_SUB  = ALUC_W'(2);
  localparam logic [ALUC_W-1:0] ALUC_MOVI = ALUC_W'(7);
  localparam logic [ALUC_W-1:0] ALUC_MOVR = ALUC_W'(8);

  typedef struct packed {
    logic              rn_src;
    logic              imm_src;
    logic              rs_src;
    logic              result_src;
    logic              io_flag;
    logic              pau_op;
    logic              imm_ext;
    logic              flag_write;
    logic              alu_src;
    logic              branch_inst;
    logic              mem_write;
    logic              reg_write;
    logic              mem_p_write;
    logic [ALUC_W-1:0] alu_control;
    logic [COND_W-1:0] cond_flag;
    logic [1:0]        mem_to_reg;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/cu_decode.sv
// Combinational header decoder: header -> control bundle, illegal flag and
// a marker for multi-cycle PAU operations.
module cu_decode
  import cu_pkg::*;
(
  input  logic [HDR_W-1:0] header_i,
  output ctrl_bundle_t     bundle_o,
  output logic             illegal_o,
  output logic             is_pau_o
);

  cls_e              cls;
  logic              imm;
  logic [OP_W-1:0]   op;
  logic [COND_W-1:0] cond;

  always_comb begin
    bundle_o  = CTRL_NOP;
    illegal_o = 1'b0;
    is_pau_o  = 1'b0;
    cls       = cls_e'(header_i[OP_W+2:OP_W+1]);
    imm       = header_i[OP_W];
    op        = header_i[OP_W-1:0];
    cond      = header_i[HDR_W-1 -: COND_W];

    case (cls)
      CL_DATA: begin
        if (imm) begin
          case (op)
            OP_SUB, OP_ADD, OP_MOV: begin
              bundle_o.imm_ext    = 1'b1;
              bundle_o.alu_src    = 1'b1;
              bundle_o.reg_write  = 1'b1;
              bundle_o.mem_to_reg = 2'b01;
              bundle_o.alu_control = (op == OP_SUB) ? ALUC_SUB :
                                     (op == OP_ADD) ? ALUC_ADD : ALUC_MOVI;
            end
            OP_CMP: begin
              bundle_o.rn_src      = 1'b1;
              bundle_o.imm_ext     = 1'b1;
              bundle_o.alu_src     = 1'b1;
              bundle_o.flag_write  = 1'b1;
              bundle_o.alu_control = ALUC_SUB;
            end
            default: illegal_o = 1'b1;
          endcase
        end else begin
          case (op)
            OP_SUB, OP_ADD: begin
              bundle_o.reg_write   = 1'b1;
              bundle_o.mem_to_reg  = 2'b01;
              bundle_o.alu_control = (op == OP_SUB) ? ALUC_SUB : ALUC_ADD;
            end
            OP_CMP: begin
              bundle_o.rs_src      = 1'b1;
              bundle_o.flag_write  = 1'b1;
              bundle_o.alu_control = ALUC_SUB;
            end
            OP_MOV: begin
              bundle_o.rs_src      = 1'b1;
              bundle_o.reg_write   = 1'b1;
              bundle_o.alu_control = ALUC_MOVR;
              bundle_o.mem_to_reg  = 2'b01;
            end
            OP_AVR, OP_CUM: begin
              bundle_o.result_src = 1'b1;
              bundle_o.reg_write  = 1'b1;
              bundle_o.mem_to_reg = 2'b01;
              bundle_o.pau_op     = (op == OP_CUM);
              is_pau_o            = 1'b1;
            end
            default: illegal_o = 1'b1;
          endcase
        end
      end
      // Memory ops are selected by the imm bit and the top opcode bit.
      CL_MEM: begin
        case (header_i[OP_W -: 2])
          2'b00: begin
            bundle_o.imm_ext     = 1'b1;
            bundle_o.rs_src      = 1'b1;
            bundle_o.alu_src     = 1'b1;
            bundle_o.mem_write   = 1'b1;
            bundle_o.alu_control = ALUC_ADD;
          end
          2'b11: begin
            bundle_o.imm_ext     = 1'b1;
            bundle_o.rs_src      = 1'b1;
            bundle_o.alu_src     = 1'b1;
            bundle_o.reg_write   = 1'b1;
            bundle_o.alu_control = ALUC_ADD;
            bundle_o.mem_to_reg  = 2'b00;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      CL_BRANCH: begin
        bundle_o.branch_inst = 1'b1;
        bundle_o.imm_src     = 1'b1;
        bundle_o.cond_flag   = cond;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered control unit: one-cycle decode with valid/ready handshake, stall
// hold, branch flush and an FSM that delays PAU results by PAU_LAT cycles.
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned PAU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [HDR_W-1:0]  inst_header,
  input  logic              stall_in,
  input  logic              flush,
  output logic              ctrl_valid,
  output logic              illegal,
  output logic              RnSrc,
  output logic              ImmSrc,
  output logic              RsSrc,
  output logic              ResultSrc,
  output logic              IOFlag,
  output logic              PAUOp,
  output logic              ImmExt,
  output logic              FlagWrite,
  output logic              ALUSrc,
  output logic              BranchInst,
  output logic              MemWrite,
  output logic              RegWrite,
  output logic              MemPWrite,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [COND_W-1:0] CondFlag,
  output logic [1:0]        MemToReg
);

  localparam int unsigned    CNT_W     = (PAU_LAT > 2) ? $clog2(PAU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((PAU_LAT >= 2) ? (PAU_LAT - 2) : 0);
  localparam bit             PAU_MULTI = (PAU_LAT > 1);

  typedef enum logic {S_IDLE, S_PAU_RUN} state_e;

  state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_bundle_t pend_q, pend_d;
  ctrl_bundle_t out_q, out_d;
  logic         valid_q, valid_d;
  logic         illegal_q, illegal_d;

  ctrl_bundle_t dec_bundle;
  logic         dec_illegal;
  logic         dec_is_pau;
  logic         accept;

  cu_decode u_decode (
    .header_i  (inst_header),
    .bundle_o  (dec_bundle),
    .illegal_o (dec_illegal),
    .is_pau_o  (dec_is_pau)
  );

  assign inst_ready = (state_q == S_IDLE) && !(valid_q && stall_in);
  assign accept     = inst_valid && inst_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_q    <= CTRL_NOP;
      out_q     <= CTRL_NOP;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state: flush dominates, then stall hold, then accept / PAU sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    out_d     = out_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;

    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pend_d    = CTRL_NOP;
      out_d     = CTRL_NOP;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_q && stall_in) begin
            // hold bundle for the stalled execute stage
          end else if (accept && dec_is_pau && PAU_MULTI) begin
            state_d   = S_PAU_RUN;
            cnt_d     = CNT_LOAD;
            pend_d    = dec_bundle;
            out_d     = CTRL_NOP;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
          end else if (accept) begin
            out_d     = dec_bundle;
            valid_d   = 1'b1;
            illegal_d = dec_illegal;
          end else begin
            out_d     = CTRL_NOP;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
          end
        end
        S_PAU_RUN: begin
          if (cnt_q == '0) begin
            state_d   = S_IDLE;
            out_d     = pend_q;
            valid_d   = 1'b1;
            illegal_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ctrl_valid = valid_q;
  assign illegal    = illegal_q;
  assign RnSrc      = out_q.rn_src;
  assign ImmSrc     = out_q.imm_src;
  assign RsSrc      = out_q.rs_src;
  assign ResultSrc  = out_q.result_src;
  assign IOFlag     = out_q.io_flag;
  assign PAUOp      = out_q.pau_op;
  assign ImmExt     = out_q.imm_ext;
  assign FlagWrite  = out_q.flag_write;
  assign ALUSrc     = out_q.alu_src;
  assign BranchInst = out_q.branch_inst;
  assign MemWrite   = out_q.mem_write;
  assign RegWrite   = out_q.reg_write;
  assign MemPWrite  = out_q.mem_p_write;
  assign ALUControl = out_q.alu_control;
  assign CondFlag   = out_q.cond_flag;
  assign MemToReg   = out_q.mem_to_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Randomized bench for pipelined_control_unit against a time-stamped
// transaction model of the decode table, stall, flush and PAU latency.
module tb_pipelined_control_unit;

  localparam int unsigned PAU_LAT = 4;

  logic       clk;
  logic       rst;
  logic       inst_valid;
  logic       inst_ready;
  logic [9:0] inst_header;
  logic       stall_in;
  logic       flush;
  logic       ctrl_valid;
  logic       illegal;
  logic       RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt;
  logic       FlagWrite, ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite;
  logic [3:0] ALUControl;
  logic [2:0] CondFlag;
  logic [1:0] MemToReg;

  int checks;
  int failures;

  // model: visible outputs plus one pending PAU result with its due cycle
  int          cyc;
  logic        m_valid, m_ill, m_pend;
  logic [21:0] m_bundle, m_pend_b;
  int          m_due;

  pipelined_control_unit #(.PAU_LAT(PAU_LAT)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_header(inst_header), .stall_in(stall_in), .flush(flush),
    .ctrl_valid(ctrl_valid), .illegal(illegal),
    .RnSrc(RnSrc), .ImmSrc(ImmSrc), .RsSrc(RsSrc), .ResultSrc(ResultSrc),
    .IOFlag(IOFlag), .PAUOp(PAUOp), .ImmExt(ImmExt), .FlagWrite(FlagWrite),
    .ALUSrc(ALUSrc), .BranchInst(BranchInst), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemPWrite(MemPWrite), .ALUControl(ALUControl),
    .CondFlag(CondFlag), .MemToReg(MemToReg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_decode(input logic [9:0] h, output logic [21:0] b,
                                     output logic ill, output logic pau);
    logic rn, ims, rs, res, pop, ie, fw, as, br, mw, rw;
    logic [3:0] alu;
    logic [2:0] cf;
    logic [1:0] mtr;
    logic [3:0] op;
    {rn, ims, rs, res, pop, ie, fw, as, br, mw, rw} = '0;
    alu = '0; cf = '0; mtr = '0; ill = 1'b0; pau = 1'b0;
    op = h[3:0];
    case (h[6:5])
      2'b00: begin
        if (h[4]) begin
          if (op == 4'd1 || op == 4'd2 || op == 4'd3) begin
            ie = 1; as = 1; rw = 1; mtr = 2'b01;
            alu = (op == 4'd1) ? 4'd2 : (op == 4'd2) ? 4'd1 : 4'd7;
          end else if (op == 4'd7) begin
            rn = 1; ie = 1; as = 1; fw = 1; alu = 4'd2;
          end else ill = 1'b1;
        end else begin
          if (op == 4'd1 || op == 4'd2) begin
            rw = 1; mtr = 2'b01; alu = (op == 4'd1) ? 4'd2 : 4'd1;
          end else if (op == 4'd7) begin
            rs = 1; fw = 1; alu = 4'd2;
          end else if (op == 4'd3) begin
            rs = 1; rw = 1; alu = 4'd8; mtr = 2'b01;
          end else if (op == 4'd10 || op == 4'd11) begin
            res = 1; rw = 1; mtr = 2'b01; pop = (op == 4'd11); pau = 1'b1;
          end else ill = 1'b1;
        end
      end
      2'b01: begin
        if (h[4:3] == 2'b00) begin
          ie = 1; rs = 1; as = 1; mw = 1; alu = 4'd1;
        end else if (h[4:3] == 2'b11) begin
          ie = 1; rs = 1; as = 1; rw = 1; alu = 4'd1;
        end else ill = 1'b1;
      end
      2'b10: begin
        br = 1; ims = 1; cf = h[9:7];
      end
      default: ill = 1'b1;
    endcase
    b = {rn, ims, rs, res, 1'b0, pop, ie, fw, as, br, mw, rw, 1'b0, alu, cf, mtr};
  endfunction

  task automatic check_outputs();
    logic [21:0] obs;
    obs = {RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt, FlagWrite,
           ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite, ALUControl,
           CondFlag, MemToReg};
    check_eq("ctrl_valid", 32'(ctrl_valid), 32'(m_valid));
    check_eq("illegal", 32'(illegal), 32'(m_ill));
    check_eq("bundle", 32'(obs), 32'(m_bundle));
  endtask

  // One clock: check outputs, drive inputs, check ready, then advance model.
  task automatic step(input logic v, input logic [9:0] h, input logic s,
                      input logic f, input logic r);
    logic exp_ready, acc, ill, pau;
    logic [21:0] b;
    @(negedge clk);
    check_outputs();
    inst_valid = v; inst_header = h; stall_in = s; flush = f; rst = r;
    #1;
    exp_ready = !m_pend && !(m_valid && s);
    check_eq("inst_ready", 32'(inst_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    cyc++;
    ref_decode(h, b, ill, pau);
    if (r || f) begin
      m_valid = 0; m_ill = 0; m_bundle = '0; m_pend = 0;
    end else if (m_valid && s) begin
      // held
    end else if (m_pend) begin
      if (cyc == m_due) begin
        m_valid = 1; m_ill = 0; m_bundle = m_pend_b; m_pend = 0;
      end else begin
        m_valid = 0; m_ill = 0; m_bundle = '0;
      end
    end else if (acc && pau && PAU_LAT > 1) begin
      m_pend = 1; m_pend_b = b; m_due = cyc + int'(PAU_LAT) - 1;
      m_valid = 0; m_ill = 0; m_bundle = '0;
    end else if (acc) begin
      m_valid = 1; m_ill = ill; m_bundle = b;
    end else begin
      m_valid = 0; m_ill = 0; m_bundle = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
  endtask

  localparam logic [9:0] H_ADDI = 10'b000_00_1_0010;
  localparam logic [9:0] H_SUBI = 10'b000_00_1_0001;
  localparam logic [9:0] H_ADDR = 10'b000_00_0_0010;
  localparam logic [9:0] H_CMPI = 10'b000_00_1_0111;
  localparam logic [9:0] H_CUM  = 10'b000_00_0_1011;
  localparam logic [9:0] H_AVR  = 10'b000_00_0_1010;
  localparam logic [9:0] H_LDR  = 10'b000_01_1_1000;
  localparam logic [9:0] H_STR  = 10'b000_01_0_0000;
  localparam logic [9:0] H_BR   = 10'b101_10_0_0000;
  localparam logic [9:0] H_RSVD = 10'b000_11_0_0001;

  initial begin
    logic [9:0] legal [10];
    logic [9:0] h;
    checks = 0; failures = 0; cyc = 0;
    m_valid = 0; m_ill = 0; m_pend = 0; m_bundle = '0; m_pend_b = '0; m_due = 0;
    inst_valid = 0; inst_header = '0; stall_in = 0; flush = 0; rst = 1;
    legal = '{H_ADDI, H_SUBI, H_ADDR, H_CMPI, H_CUM, H_AVR, H_LDR, H_STR, H_BR,
              10'b000_00_0_0011};

    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    idle(1);
    check_eq("reset_ready", 32'(inst_ready), 32'd1);
    check_eq("reset_valid", 32'(ctrl_valid), 32'd0);

    step(1, H_ADDI, 0, 0, 0);
    @(negedge clk);
    check_eq("addi_aluc", 32'(ALUControl), 32'd1);
    check_eq("addi_mtr", 32'(MemToReg), 32'd1);
    idle(2);

    step(1, H_CUM, 0, 0, 0);
    idle(5);

    step(1, H_LDR, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
    step(1, H_ADDI, 0, 0, 0);
    idle(1);

    step(1, H_BR, 0, 0, 0);
    @(negedge clk);
    check_eq("br_cond", 32'(CondFlag), 32'd5);
    idle(1);

    step(1, H_CUM, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(1, H_ADDI, 0, 1, 0);
    idle(5);

    step(1, H_RSVD, 0, 0, 0);
    idle(1);

    step(1, H_SUBI, 0, 0, 0);
    step(1, H_ADDR, 0, 0, 0);
    step(1, H_CMPI, 0, 0, 0);
    idle(1);

    step(1, H_LDR, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 1, 0);
    idle(1);

    step(1, H_AVR, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    idle(5);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 7) h = legal[$urandom_range(0, 9)];
      else h = 10'($urandom);
      step(1'($urandom_range(0, 2) != 0), h,
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 49) == 0));
    end
    idle(6);
    @(negedge clk);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Registered successor to the combinational decoder. Decodes the instruction header into the datapath control bundle with one cycle of latency, and adds a valid/ready handshake, downstream stall hold and branch flush. Multi-cycle PAU ops (AVR, CUM) are sequenced by an FSM so RegWrite lines up with the PAU result. Sits between the fetch/header register and the execute stage.

Parameters:
COND_W, 3, condition field width, header[HDR_W-1 -: COND_W]
OP_W, 4, opcode field width, header[OP_W-1:0]
ALUC_W, 4, ALUControl width
PAU_LAT, 4, PAU op cycles from accept to result (>=1)
HDR_W, COND_W+3+OP_W (=10), derived, not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_valid  in  1  header valid
inst_ready  out  1  block accepts header this cycle
inst_header  in  HDR_W  [cond | class(2) | imm(1) | op]
stall_in  in  1  execute cannot take bundle; hold output
flush  in  1  branch taken; kill in-flight work
ctrl_valid  out  1  bundle valid
illegal  out  1  decoded header was undefined (bundle = NOP)
RnSrc, ImmSrc, RsSrc, ResultSrc, IOFlag, PAUOp, ImmExt, FlagWrite, ALUSrc, BranchInst, MemWrite, RegWrite, MemPWrite  out  1 each  control bundle
ALUControl  out  ALUC_W  ALU op
CondFlag  out  COND_W  branch condition
MemToReg  out  2  writeback select

Behaviour:
- Reset: all outputs 0 except inst_ready=1; FSM IDLE; counter 0.
- Accept = inst_valid && inst_ready. inst_ready = (state==IDLE) && !(ctrl_valid && stall_in).
- Decode table (class=header[OP_W+2:OP_W+1], imm=header[OP_W], op):
  - class 00 imm=1: SUB op1 ALUC=2, ADD op2 ALUC=1, MOV op3 ALUC=7. All have ImmExt, ALUSrc, RegWrite, MemToReg=01. CMP op7: RnSrc, ImmExt, ALUSrc, FlagWrite, ALUC=2.
  - class 00 imm=0: SUB/ADD as above without ImmExt/ALUSrc. CMP op7: RsSrc, FlagWrite, ALUC=2. MOV op3: RsSrc, RegWrite, ALUC=8, MemToReg=01. AVR op10: ResultSrc, RegWrite, MemToReg=01. CUM op11: as AVR plus PAUOp.
  - class 01: header[OP_W:OP_W-1]=00 STR (ImmExt, RsSrc, ALUSrc, MemWrite, ALUC=1). 11 LDR (same, RegWrite instead of MemWrite, MemToReg=00).
  - class 10: BranchInst, ImmSrc, CondFlag=cond field.
  - class 11 and any unlisted op: all-zero bundle, illegal=1.
- Non-PAU accept: bundle registered; ctrl_valid=1 the next cycle (latency 1).
- Empty cycle (IDLE, no accept, not stalled): ctrl_valid=0 and bundle cleared to 0.
- Stall: while ctrl_valid && stall_in, bundle, ctrl_valid and illegal hold unchanged.
- FSM IDLE -> PAU_RUN on accept of AVR/CUM when PAU_LAT>1. Counter loads PAU_LAT-2 and decrements each cycle. ctrl_valid stays 0 and the decoded bundle is kept internally. At counter==0: bundle -> outputs, ctrl_valid=1, state -> IDLE. Total latency = PAU_LAT cycles.
- PAU_LAT=1: PAU ops behave like non-PAU ops.
- Counter width $clog2(PAU_LAT). No wrap: the counter is only loaded in IDLE.
- flush has priority over everything. Next cycle: ctrl_valid=0, illegal=0, bundle=0, state=IDLE. A same-cycle accept is dropped. A flush during stall also clears.
- rst mid PAU_RUN: identical to the reset state next cycle.

Decomposition:
- Package cu_pkg:
  - class enum {CL_DATA, CL_MEM, CL_BRANCH, CL_RSVD}
  - opcode localparams (OP_SUB=1, OP_ADD=2, OP_MOV=3, OP_CMP=7, OP_AVR=10, OP_CUM=11)
  - ALUC constants
  - packed struct ctrl_bundle_t with NOP constant
- Sub-module cu_decode: pure combinational header -> {ctrl_bundle_t, illegal, is_pau}.
- Top owns the FSM, counter, output register and handshake.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, inst_ready=1.
- ADD imm (hdr 10'b000_00_1_0010), valid 1 cycle -> next cycle ctrl_valid=1, ALUControl=1, ImmExt=ALUSrc=RegWrite=1, MemToReg=01; then ctrl_valid=0.
- CUM (hdr 10'b000_00_0_1011), PAU_LAT=4 -> inst_ready=0 for 3 cycles; ctrl_valid=1 with PAUOp=ResultSrc=RegWrite=1 exactly 4 cycles after accept.
- LDR issued then stall_in=1 for 3 cycles -> bundle held and inst_ready=0; after release, next header accepted the same cycle.
- Branch hdr 10'b101_10_0_0000 -> BranchInst=1, CondFlag=3'b101. flush asserted mid CUM at cycle 2 -> ctrl_valid never rises, IDLE next cycle.
- Class 11 header -> ctrl_valid=1, illegal=1, all control 0. Back-to-back SUB/ADD/CMP each decoded correctly, one per cycle.
